// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: NOP/HALT encodings, FSM state type, PC helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam logic [15:0] FETCH_NOP_INSTR = 16'h4000;
  localparam logic [3:0]  FETCH_HALT_OP   = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_HALTED   = 2'd2
  } fetch_state_e;

  // Sequential PC step; 16-bit wrap from 16'hFFFE to 16'h0000 is intended.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: I-cache request/response, ID redirect, hazard stall, IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: stall_in holds the fetch stage; imem_rdy low stretches a request.
interface fetch_unit_if;
  logic        stall_in;
  logic        br_taken;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] IF_pc;
  logic [15:0] IF_instr;
  logic        IF_valid;
  logic [15:0] fetch_miss_cnt;
  logic [15:0] fetch_instr_cnt;

  // Fetch unit side.
  modport master (
    input  stall_in, br_taken, br_target, imem_rdy, imem_data,
    output imem_req, imem_addr, IF_pc, IF_instr, IF_valid,
    output fetch_miss_cnt, fetch_instr_cnt
  );

  // Environment side (cache, ID, hazard unit, IF/ID register).
  modport slave (
    output stall_in, br_taken, br_target, imem_rdy, imem_data,
    input  imem_req, imem_addr, IF_pc, IF_instr, IF_valid,
    input  fetch_miss_cnt, fetch_instr_cnt
  );
endinterface

// File: rtl/pldff.sv
// Write-enabled pipeline flop with synchronous active-high reset to RESET_VAL.
// Latency: 1 cycle from i_d to o_q when i_en is high.
// Backpressure: i_en low holds the current value.
module pldff #(
  parameter int unsigned     WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Load on enable, reset wins.
  always_ff @(posedge clk) begin
    if (rst)       r_q <= RESET_VAL;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/sat_counter.sv
// Generic saturating up-counter, cleared by synchronous active-high reset.
// Latency: count visible 1 cycle after the i_inc cycle.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Increment until all-ones, then hold.
  always_ff @(posedge clk) begin
    if (rst)                          r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the I-cache, feeds IF/ID; perf counters under FETCH_PERF_CNT_EN.
// Latency: zero-cycle hit (imem_data to IF_instr combinationally); misses insert bubbles.
// Backpressure: stall_in holds PC and output; misses park in WAIT_MEM, redirects there are queued.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = FETCH_NOP_INSTR,
  parameter logic [3:0]  HALT_OP   = FETCH_HALT_OP
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);

  logic [15:0]  r_pc;
  logic [15:0]  r_pend_target;
  logic [1:0]   r_state;
  logic         r_pend_valid;

  logic [15:0]  w_pc_d;
  logic         w_pc_en;
  logic [15:0]  w_pend_target_d;
  logic         w_pend_target_en;
  logic [1:0]   w_state_d;
  logic         w_state_en;
  logic         w_pend_valid_d;

  logic         w_req;
  logic         w_deliver;
  logic         w_out_valid;
  logic         w_redirect;
  logic         w_halt_op;
  logic [15:0]  w_pc_plus2;
  fetch_state_e w_state;

  assign w_state    = fetch_state_e'(r_state);
  assign w_pc_plus2 = pc_inc(r_pc);
  // A stalled ID re-presents its branch later, so only unstalled redirects count.
  assign w_redirect = bus.br_taken & ~bus.stall_in;
  assign w_halt_op  = (bus.imem_data[15:12] == HALT_OP);

  pldff #(.WIDTH(16), .RESET_VAL(RESET_PC)) u_pc (
    .clk (clk), .rst (rst), .i_en (w_pc_en), .i_d (w_pc_d), .o_q (r_pc)
  );

  pldff #(.WIDTH(16), .RESET_VAL(16'h0000)) u_pend_target (
    .clk (clk), .rst (rst), .i_en (w_pend_target_en), .i_d (w_pend_target_d), .o_q (r_pend_target)
  );

  pldff #(.WIDTH(2), .RESET_VAL(ST_FETCH)) u_state (
    .clk (clk), .rst (rst), .i_en (w_state_en), .i_d (w_state_d), .o_q (r_state)
  );

  // Pending-redirect flag for branches that resolve while a miss is outstanding.
  always_ff @(posedge clk) begin
    if (rst) r_pend_valid <= 1'b0;
    else     r_pend_valid <= w_pend_valid_d;
  end

  // Next-state, next-PC and pending-redirect decisions.
  always_comb begin
    w_pc_en          = 1'b0;
    w_pc_d           = r_pc;
    w_state_en       = 1'b0;
    w_state_d        = r_state;
    w_pend_target_en = 1'b0;
    w_pend_target_d  = bus.br_target;
    w_pend_valid_d   = r_pend_valid;
    w_req            = 1'b0;
    w_deliver        = 1'b0;

    case (w_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (bus.imem_rdy) begin
          w_deliver = 1'b1;
        end else begin
          w_state_en = 1'b1;
          w_state_d  = ST_WAIT_MEM;
          // The miss cannot be cancelled, so a same-cycle redirect is queued.
          if (w_redirect) begin
            w_pend_target_en = 1'b1;
            w_pend_valid_d   = 1'b1;
          end
        end
      end

      ST_WAIT_MEM: begin
        w_req = 1'b1;
        if (bus.imem_rdy) begin
          w_state_en = 1'b1;
          w_state_d  = ST_FETCH;
          if (w_redirect) begin
            // Fresh redirect beats both the returned word and any queued target.
            w_pc_en        = 1'b1;
            w_pc_d         = bus.br_target;
            w_pend_valid_d = 1'b0;
          end else if (r_pend_valid) begin
            w_pc_en        = 1'b1;
            w_pc_d         = r_pend_target;
            w_pend_valid_d = 1'b0;
          end else begin
            w_deliver = 1'b1;
          end
        end else if (w_redirect) begin
          // Later redirects overwrite earlier ones.
          w_pend_target_en = 1'b1;
          w_pend_valid_d   = 1'b1;
        end
      end

      ST_HALTED: begin
        // Only a taken branch can leave HALTED: the HLT was on the wrong path.
        if (w_redirect) begin
          w_pc_en    = 1'b1;
          w_pc_d     = bus.br_target;
          w_state_en = 1'b1;
          w_state_d  = ST_FETCH;
        end
      end

      default: begin
        w_state_en = 1'b1;
        w_state_d  = ST_FETCH;
      end
    endcase

    // Next-PC for a delivered word; a stall holds everything.
    if (w_deliver && !bus.stall_in) begin
      if (bus.br_taken) begin
        w_pc_en = 1'b1;
        w_pc_d  = bus.br_target;
      end else if (w_halt_op) begin
        w_state_en = 1'b1;
        w_state_d  = ST_HALTED;
      end else begin
        w_pc_en = 1'b1;
        w_pc_d  = w_pc_plus2;
      end
    end
  end

  // Outputs are bubbles while reset is held so the cache sees no request.
  assign w_out_valid   = w_deliver & ~rst;
  assign bus.imem_req  = w_req & ~rst;
  assign bus.imem_addr = r_pc;
  assign bus.IF_valid  = w_out_valid;
  assign bus.IF_instr  = w_out_valid ? bus.imem_data : NOP_INSTR;
  assign bus.IF_pc     = w_out_valid ? w_pc_plus2 : 16'h0000;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] w_miss_cnt;
  logic [15:0] w_instr_cnt;

  sat_counter #(.WIDTH(16)) u_miss_cnt (
    .clk (clk), .rst (rst), .i_inc (w_state == ST_WAIT_MEM), .o_cnt (w_miss_cnt)
  );

  sat_counter #(.WIDTH(16)) u_instr_cnt (
    .clk (clk), .rst (rst), .i_inc (w_out_valid & ~bus.stall_in), .o_cnt (w_instr_cnt)
  );

  assign bus.fetch_miss_cnt  = w_miss_cnt;
  assign bus.fetch_instr_cnt = w_instr_cnt;
`else
  assign bus.fetch_miss_cnt  = 16'h0000;
  assign bus.fetch_instr_cnt = 16'h0000;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; producer side of the IF/ID pipeline register.
- Owns the PC and drives the instruction-cache request.
- Applies branch redirects from ID and hazard stalls from the hazard unit.
- Inserts NOP bubbles on cache misses and after HLT. Its outputs connect directly to IF/ID's IF_pc / IF_instr inputs.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h4000, bubble encoding driven on IF_instr when no valid instruction is available.
- HALT_OP, 4'hF, opcode (instr[15:12]) that halts fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_in  in  1  hazard stall; hold PC and current output.
- br_taken  in  1  ID-stage branch/jump resolved taken.
- br_target  in  16  redirect address, valid with br_taken.
- imem_req  out  1  cache read request.
- imem_addr  out  16  cache read address (= PC).
- imem_rdy  in  1  data valid this cycle (same-cycle on hit, later on miss).
- imem_data  in  16  instruction word, valid when imem_rdy.
- IF_pc  out  16  PC+2 of the delivered instruction (0 on bubble).
- IF_instr  out  16  delivered instruction or NOP_INSTR.
- IF_valid  out  1  IF_instr is a real fetched instruction.
- fetch_miss_cnt  out  16  perf counter (optional feature).
- fetch_instr_cnt  out  16  perf counter (optional feature).

Behaviour:
- Reset:
  - pc=RESET_PC, state=FETCH, pend_valid=0, pend_target=0.
  - Outputs IF_valid=0, IF_instr=NOP_INSTR, IF_pc=0, imem_req=0.
- States: FETCH, WAIT_MEM, HALTED.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_rdy=1: IF_instr=imem_data, IF_pc=pc+2, IF_valid=1 (combinational, zero latency).
  - Next pc when stall_in=0:
    - br_taken → br_target; delivered word is wrong-path, IF/ID flush discards it.
    - else opcode==HALT_OP → stay at pc, go HALTED.
    - else pc+2.
  - stall_in=1: pc held; br_taken ignored (ID re-presents it after the stall).
  - imem_rdy=0: IF_valid=0, IF_instr=NOP_INSTR, go WAIT_MEM.
- WAIT_MEM:
  - imem_req=1, imem_addr held at pc (outstanding miss is never cancelled); outputs are bubble.
  - br_taken with stall_in=0: pend_valid<=1, pend_target<=br_target. Later redirects overwrite pend_target.
  - On imem_rdy with pend_valid=1: data discarded, output bubble, pc<=pend_target, pend_valid<=0, go FETCH.
  - On imem_rdy with pend_valid=0: deliver the word as in FETCH, same next-PC rules.
  - A redirect arriving in the same cycle as imem_rdy takes priority over data and pend_target.
- HALTED:
  - imem_req=0, outputs bubble, pc frozen.
  - br_taken with stall_in=0 → pc<=br_target, go FETCH (HLT was wrong-path).
- PC arithmetic: 16-bit, pc+2 wraps 16'hFFFE→16'h0000, no flag.
- rst asserted in any state, including mid-miss, returns to reset values next edge. The cache must tolerate an abandoned request.
- imem_data is ignored whenever imem_rdy=0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_miss_cnt increments each cycle in WAIT_MEM.
  - fetch_instr_cnt increments on each cycle with IF_valid=1 and stall_in=0.
  - Both 16-bit, saturate at 16'hFFFF, cleared by rst.
- Undefined: both ports tied to 16'h0000, no counter flops.

Decomposition:
- Shared package fetch_pkg: NOP encoding, HALT opcode, fetch state encoding (FETCH=2'd0, WAIT_MEM=2'd1, HALTED=2'd2).
- PC, pend_target and state use the existing write-enabled pipeline flop pldff (WIDTH=16 / 2).
- No new sub-module; the optional counters are one small generic sat_counter instance each.

Test Plan:
- Reset, then hits every cycle with words 0x1234,0x2345 → IF_pc 0x0002,0x0004, IF_valid=1, imem_addr 0x0000,0x0002,0x0004.
- stall_in=1 for 2 cycles at pc=0x0004 with br_taken=1 → imem_addr stays 0x0004, no redirect; after release PC advances to 0x0006.
- Miss at pc=0x0010 for 3 cycles, br_taken=1 target 0x0040 in cycle 2 → 3 bubbles, returned word discarded, next imem_addr=0x0040.
- Fetch 0xF000 at pc=0x0020 → IF_valid=1 once with IF_pc=0x0022, then bubbles, imem_req=0. Then br_taken target 0x0100 → fetch resumes at 0x0100.
- Hit at pc=0xFFFE → next imem_addr=0x0000.
- rst during WAIT_MEM → next cycle pc=RESET_PC, state FETCH, outputs bubble.
- With FETCH_PERF_CNT_EN defined: the 3-cycle miss gives fetch_miss_cnt=3.
